// File: rtl/rx_dfe_slicer_pkg.sv
// rx_pkg: shared types, sizes and slicer helpers for the rx_dfe_slicer block.
// Optional error outputs are enabled by defining RX_DFE_ERR_OUT_EN.
package rx_pkg;

    localparam int DATA_W    = 8;
    localparam int COEF_W    = 8;
    localparam int COEF_FRAC = 2;
    localparam int NTAPS     = 4;
    localparam int LEVEL     = 32;
    localparam int NUM_LANES = 4;
    localparam int TAP_W     = $clog2(NTAPS);
    localparam int LANE_W    = $clog2(NUM_LANES);
    // Equalised sample width: wide enough that sample minus feedback never wraps.
    localparam int Y_W       = DATA_W + COEF_W + $clog2(NTAPS) + 2;

    typedef logic signed [2:0] pam5_t;

    localparam pam5_t PAM5_P2 = 3'sd2;
    localparam pam5_t PAM5_P1 = 3'sd1;
    localparam pam5_t PAM5_Z  = 3'sd0;
    localparam pam5_t PAM5_M1 = -3'sd1;
    localparam pam5_t PAM5_M2 = -3'sd2;

    localparam logic signed [Y_W-1:0] LVL_Y   = Y_W'(LEVEL);
    localparam logic signed [Y_W-1:0] TH_HI   = Y_W'((3 * LEVEL) / 2);
    localparam logic signed [Y_W-1:0] TH_LO   = Y_W'(LEVEL / 2);
    localparam logic signed [Y_W-1:0] ERR_MAX = Y_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [Y_W-1:0] ERR_MIN = Y_W'(-(1 << (DATA_W - 1)));

    // Ties at +/-LEVEL/2 go away from zero; +/-3*LEVEL/2 map to +/-2.
    function automatic pam5_t pam5_slice(input logic signed [Y_W-1:0] y);
        pam5_t d;
        if (y >= TH_HI)       d = PAM5_P2;
        else if (y >= TH_LO)  d = PAM5_P1;
        else if (y > -TH_LO)  d = PAM5_Z;
        else if (y > -TH_HI)  d = PAM5_M1;
        else                  d = PAM5_M2;
        return d;
    endfunction

endpackage

// File: rtl/rx_dfe_slicer_if.sv
// rx_dfe_slicer_if: sample, decision and coefficient-write signals of the DFE.
// Error outputs exist only when RX_DFE_ERR_OUT_EN is defined.
//
// Handshake: valid-only, no backpressure. io_in_valid qualifies all four lane
// samples in the same cycle; io_out_valid qualifies all four decisions one
// cycle later. When io_out_valid is low the decision bits hold their value.
// cfg_wr_en is a single-cycle write strobe, always accepted.
interface rx_dfe_slicer_if;
    import rx_pkg::*;

    logic                     io_in_valid;
    logic signed [DATA_W-1:0] io_in_bits_0;
    logic signed [DATA_W-1:0] io_in_bits_1;
    logic signed [DATA_W-1:0] io_in_bits_2;
    logic signed [DATA_W-1:0] io_in_bits_3;
    logic                     cfg_wr_en;
    logic [LANE_W-1:0]        cfg_wr_lane;
    logic [TAP_W-1:0]         cfg_wr_tap;
    logic signed [COEF_W-1:0] cfg_wr_data;
    logic                     io_out_valid;
    pam5_t                    io_out_bits_0;
    pam5_t                    io_out_bits_1;
    pam5_t                    io_out_bits_2;
    pam5_t                    io_out_bits_3;
`ifdef RX_DFE_ERR_OUT_EN
    logic signed [DATA_W-1:0] io_err_bits_0;
    logic signed [DATA_W-1:0] io_err_bits_1;
    logic signed [DATA_W-1:0] io_err_bits_2;
    logic signed [DATA_W-1:0] io_err_bits_3;
`endif

    modport master (
        output io_in_valid, io_in_bits_0, io_in_bits_1, io_in_bits_2, io_in_bits_3,
        output cfg_wr_en, cfg_wr_lane, cfg_wr_tap, cfg_wr_data,
`ifdef RX_DFE_ERR_OUT_EN
        input  io_err_bits_0, io_err_bits_1, io_err_bits_2, io_err_bits_3,
`endif
        input  io_out_valid, io_out_bits_0, io_out_bits_1, io_out_bits_2, io_out_bits_3
    );

    modport slave (
        input  io_in_valid, io_in_bits_0, io_in_bits_1, io_in_bits_2, io_in_bits_3,
        input  cfg_wr_en, cfg_wr_lane, cfg_wr_tap, cfg_wr_data,
`ifdef RX_DFE_ERR_OUT_EN
        output io_err_bits_0, io_err_bits_1, io_err_bits_2, io_err_bits_3,
`endif
        output io_out_valid, io_out_bits_0, io_out_bits_1, io_out_bits_2, io_out_bits_3
    );

endinterface

// File: rtl/rx_dfe_slicer_lane.sv
// rx_dfe_lane: one DFE lane -- coefficient bank, decision history, feedback sum,
// PAM5 slicer and registered decision. Optional error output under RX_DFE_ERR_OUT_EN.
module rx_dfe_lane
    import rx_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_valid,
    input  logic signed [DATA_W-1:0] i_sample,
    input  logic                     i_wr_en,
    input  logic [TAP_W-1:0]         i_wr_tap,
    input  logic signed [COEF_W-1:0] i_wr_data,
`ifdef RX_DFE_ERR_OUT_EN
    output logic signed [DATA_W-1:0] o_err,
`endif
    output pam5_t                    o_dec
);

    logic signed [COEF_W-1:0] r_coef [NTAPS];
    pam5_t                    r_hist [NTAPS];
    pam5_t                    r_dec;
    logic signed [Y_W-1:0]    w_acc;
    logic signed [Y_W-1:0]    w_fb;
    logic signed [Y_W-1:0]    w_y;
    pam5_t                    w_dec;

    // Full-precision feedback sum, floor-shifted, subtracted from the sample, then sliced.
    always_comb begin
        w_acc = '0;
        for (int k = 0; k < NTAPS; k++) begin
            w_acc = w_acc + (Y_W'(r_coef[k]) * Y_W'(r_hist[k]));
        end
        w_fb  = w_acc >>> COEF_FRAC;
        w_y   = Y_W'(i_sample) - w_fb;
        w_dec = pam5_slice(w_y);
    end

    // Coefficient bank; a write lands at the edge, so a same-cycle sample sees the old value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NTAPS; k++) r_coef[k] <= '0;
        end else if (i_wr_en) begin
            r_coef[i_wr_tap] <= i_wr_data;
        end
    end

    // Decision history and output register advance only on valid samples.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NTAPS; k++) r_hist[k] <= '0;
            r_dec <= '0;
        end else if (i_valid) begin
            r_hist[0] <= w_dec;
            for (int k = 1; k < NTAPS; k++) r_hist[k] <= r_hist[k-1];
            r_dec <= w_dec;
        end
    end

    assign o_dec = r_dec;

`ifdef RX_DFE_ERR_OUT_EN
    logic signed [Y_W-1:0]    w_err_full;
    logic signed [DATA_W-1:0] w_err;
    logic signed [DATA_W-1:0] r_err;

    // Slicer error relative to the ideal level of the chosen symbol, saturated to sample width.
    always_comb begin
        w_err_full = w_y - (Y_W'(w_dec) * LVL_Y);
        if (w_err_full > ERR_MAX)      w_err = DATA_W'(ERR_MAX);
        else if (w_err_full < ERR_MIN) w_err = DATA_W'(ERR_MIN);
        else                           w_err = DATA_W'(w_err_full);
    end

    // Error register tracks the decision register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)       r_err <= '0;
        else if (i_valid) r_err <= w_err;
    end

    assign o_err = r_err;
`endif

endmodule

// File: rtl/rx_dfe_slicer.sv
// rx_dfe_slicer: 4-lane decision-feedback equaliser with PAM5 slicer.
// Define RX_DFE_ERR_OUT_EN to add per-lane slicer error outputs.
module rx_dfe_slicer
    import rx_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    rx_dfe_slicer_if.slave bus
);

    logic signed [DATA_W-1:0] w_sample [NUM_LANES];
    pam5_t                    w_dec    [NUM_LANES];
    logic                     w_wr_en  [NUM_LANES];
    logic                     r_out_valid;

    assign w_sample[0] = bus.io_in_bits_0;
    assign w_sample[1] = bus.io_in_bits_1;
    assign w_sample[2] = bus.io_in_bits_2;
    assign w_sample[3] = bus.io_in_bits_3;

`ifdef RX_DFE_ERR_OUT_EN
    logic signed [DATA_W-1:0] w_err [NUM_LANES];
`endif

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        assign w_wr_en[l] = bus.cfg_wr_en && (bus.cfg_wr_lane == LANE_W'(l));

        rx_dfe_lane u_lane (
            .clock     (clock),
            .reset     (reset),
            .i_valid   (bus.io_in_valid),
            .i_sample  (w_sample[l]),
            .i_wr_en   (w_wr_en[l]),
            .i_wr_tap  (bus.cfg_wr_tap),
            .i_wr_data (bus.cfg_wr_data),
`ifdef RX_DFE_ERR_OUT_EN
            .o_err     (w_err[l]),
`endif
            .o_dec     (w_dec[l])
        );
    end

    // Output valid is the input valid delayed by the one-cycle decision latency.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_out_valid <= 1'b0;
        else        r_out_valid <= bus.io_in_valid;
    end

    assign bus.io_out_valid  = r_out_valid;
    assign bus.io_out_bits_0 = w_dec[0];
    assign bus.io_out_bits_1 = w_dec[1];
    assign bus.io_out_bits_2 = w_dec[2];
    assign bus.io_out_bits_3 = w_dec[3];

`ifdef RX_DFE_ERR_OUT_EN
    assign bus.io_err_bits_0 = w_err[0];
    assign bus.io_err_bits_1 = w_err[1];
    assign bus.io_err_bits_2 = w_err[2];
    assign bus.io_err_bits_3 = w_err[3];
`endif

endmodule
